// File: rtl/scnn_comp_pkg.sv
// Shared types and sizes for the SCNN zero-run compressor/decompressor pair.
// Both ends import this package so their vector geometry always agrees.
package scnn_comp_pkg;

    localparam int DATA_W  = 16;
    localparam int VEC_LEN = 16;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 5;

    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t [VEC_LEN-1:0] dvec_t;

    typedef enum logic {FILL, EMIT} dec_state_t;

endpackage

// File: rtl/scnn_decompression_ips.sv
// Streaming zero-run decoder: collects (value, preceding-zero-run) entries into a
// dense vector and hands the whole vector out with a write count and an overflow flag.
module scnn_decompression_ips
    import scnn_comp_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [IDX_W-1:0]            in_zrun,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [VEC_LEN*DATA_W-1:0]   out_vec,
    output logic [CNT_W-1:0]            out_nnz,
    output logic                        out_err
);

    localparam int SLOT_W = $clog2(VEC_LEN);

    dec_state_t        state_q;
    logic [IDX_W:0]    pos_q;
    logic [CNT_W-1:0]  nnz_q;
    logic              err_q;
    dvec_t             vec_q;

    logic [IDX_W:0]    tgt;
    logic              drop;

    // One extra bit on the target keeps pos+zrun from wrapping back into range.
    always_comb begin
        tgt  = pos_q + {1'b0, in_zrun};
        drop = (tgt >= (IDX_W+1)'(VEC_LEN));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            pos_q   <= '0;
            nnz_q   <= '0;
            err_q   <= 1'b0;
            vec_q   <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        if (drop) begin
                            err_q <= 1'b1;
                        end else begin
                            vec_q[tgt[SLOT_W-1:0]] <= in_data;
                            pos_q <= tgt + (IDX_W+1)'(1);
                            nnz_q <= nnz_q + CNT_W'(1);
                        end
                        if (in_last) begin
                            state_q <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    // Clearing here means unwritten slots of the next frame read as zero.
                    if (out_ready) begin
                        state_q <= FILL;
                        pos_q   <= '0;
                        nnz_q   <= '0;
                        err_q   <= 1'b0;
                        vec_q   <= '0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == EMIT);
    assign out_vec   = vec_q;
    assign out_nnz   = nnz_q;
    assign out_err   = err_q;

endmodule
